// File: rtl/kgp_pkg.sv
// kgp_pkg: shared opcode constants, halt encoding and fetch FSM states for KGP-RISC
package kgp_pkg;
  localparam logic [5:0] OP_BLTZ = 6'b001000;
  localparam logic [5:0] OP_BZ   = 6'b001001;
  localparam logic [5:0] OP_BNZ  = 6'b001010;
  localparam logic [5:0] OP_BR   = 6'b001011;
  localparam logic [5:0] OP_B    = 6'b001100;
  localparam logic [5:0] OP_BL   = 6'b001101;
  localparam logic [5:0] OP_BCY  = 6'b001110;
  localparam logic [5:0] OP_BNCY = 6'b001111;
  localparam logic [31:0] HALT_INSTR_DEF = 32'hFFFF_FFFF;
  typedef enum logic [1:0] {FETCH, LOAD, EXEC, HALT} fetch_state_t;
endpackage

// File: rtl/branch_resolve.sv
// branch_resolve: combinational branch condition and next-PC selection
module branch_resolve
  import kgp_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [25:0] offset,
  input  logic [31:0] pc,
  input  logic [31:0] rs_data,
  input  logic        carry_flag,
  input  logic        is_branch,
  input  logic        jump_addr,
  input  logic        label_sel,
  output logic        taken,
  output logic [31:0] next_pc
);
  logic [31:0] seq, off16, off26, target;
  logic [7:0]  cond;
  // branch opcodes occupy 001xxx; the low three bits index the condition vector
  always_comb begin
    seq     = pc + 32'd4;
    off16   = {{14{offset[15]}}, offset[15:0], 2'b00};
    off26   = {{4{offset[25]}}, offset, 2'b00};
    target  = jump_addr ? {rs_data[31:2], 2'b00} : seq + (label_sel ? off16 : off26);
    cond    = {!carry_flag, carry_flag, 1'b1, 1'b1, 1'b1, |rs_data, ~|rs_data, rs_data[31]};
    taken   = is_branch && (opcode[5:3] == OP_BLTZ[5:3]) && cond[opcode[2:0]];
    next_pc = taken ? target : seq;
  end
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: KGP-RISC fetch/PC sequencing stage with IR, commit strobe and retire counter
module pc_fetch_unit
  import kgp_pkg::*;
#(
  parameter int          IMEM_AW    = 10,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = HALT_INSTR_DEF
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               stall,
  input  logic               isBranch,
  input  logic               JumpAddr,
  input  logic               LabelSel,
  input  logic [31:0]        rs_data,
  input  logic               carry_flag,
  output logic [31:0]        instr,
  output logic [5:0]         opcode,
  output logic [4:0]         func,
  output logic [31:0]        pc,
  output logic [31:0]        link_addr,
  output logic               exec_valid,
  output logic               halted,
  output logic [31:0]        instr_count
);
  fetch_state_t state, state_nx;
  logic [31:0]  ir, br_next_pc;
  logic         taken;
  assign instr     = ir;
  assign opcode    = ir[31:26];
  assign func      = ir[4:0];
  assign link_addr = pc + 32'd4;
  assign imem_addr = pc[IMEM_AW+1:2];
  branch_resolve u_br (
    .opcode    (ir[31:26]),
    .offset    (ir[25:0]),
    .pc        (pc),
    .rs_data   (rs_data),
    .carry_flag(carry_flag),
    .is_branch (isBranch),
    .jump_addr (JumpAddr),
    .label_sel (LabelSel),
    .taken     (taken),
    .next_pc   (br_next_pc)
  );
  // next-state and strobes; memory enable is held off while reset is asserted
  always_comb begin
    exec_valid = (state == EXEC) && !stall && (ir != HALT_INSTR);
    imem_en    = (state == FETCH) && !rst;
    halted     = (state == HALT);
    state_nx   = state == FETCH ? LOAD :
                 state == LOAD  ? EXEC :
                 state == EXEC  ? ((ir == HALT_INSTR) ? HALT : stall ? EXEC : FETCH) : HALT;
  end
  // state, IR capture, and PC/counter update on commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      ir          <= '0;
      instr_count <= '0;
    end else begin
      state <= state_nx;
      if (state == LOAD) ir <= imem_rdata;
      if (exec_valid) begin
        pc          <= taken ? br_next_pc : link_addr;
        instr_count <= instr_count + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: table-driven and scoreboard checks of the fetch/PC sequencing stage
module tb_pc_fetch_unit;
  logic        clk = 0, rst = 1;
  logic        imem_en, stall, isBranch, JumpAddr, LabelSel, carry_flag;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata, rs_data, instr, pc, link_addr, instr_count;
  logic [5:0]  opcode;
  logic [4:0]  func;
  logic        exec_valid, halted;
  logic [31:0] mem [1024];
  logic [31:0] exp_q [$];
  int n_cmp = 0, n_bad = 0;

  localparam logic [31:0] ADD = 32'h0000_0001;
  localparam logic [31:0] BR  = 32'h2C00_0000;

  typedef struct {
    string       nm;
    logic [31:0] start, ins;
    logic        ib, ja, ls;
    logic [31:0] rs;
    logic        cy;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[17];

  pc_fetch_unit dut (
    .clk(clk), .rst(rst), .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .stall(stall), .isBranch(isBranch), .JumpAddr(JumpAddr), .LabelSel(LabelSel),
    .rs_data(rs_data), .carry_flag(carry_flag), .instr(instr), .opcode(opcode), .func(func),
    .pc(pc), .link_addr(link_addr), .exec_valid(exec_valid), .halted(halted),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ib, input logic ja, input logic ls, input logic [31:0] rs, input logic cy);
    isBranch = ib; JumpAddr = ja; LabelSel = ls; rs_data = rs; carry_flag = cy;
  endtask

  task automatic do_reset();
    rst = 1; stall = 0;
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    #1;
  endtask

  task automatic commit(input string nm, input logic [31:0] exp_pc, input logic [31:0] exp_link);
    int t = 0;
    while (!exec_valid && t < 20) begin
      @(negedge clk); #1; t++;
    end
    if (!exec_valid) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: timeout, exec_valid 0 expected 1", nm);
      return;
    end
    chk({nm, "_link"}, link_addr, exp_link);
    exp_q.push_back(exp_pc);
    @(posedge clk); #1;
    chk({nm, "_pc"}, pc, exp_q.pop_front());
  endtask

  initial begin
    int ev;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    imem_rdata = '0;
    stall = 0;
    drive(0, 0, 0, 0, 0);
    vecs[0]  = '{"bz_taken",  32'h10,  32'h2400_0004, 1, 0, 1, 32'h0,        0, 32'h24};
    vecs[1]  = '{"bz_not",    32'h10,  32'h2400_0004, 1, 0, 1, 32'h5,        0, 32'h14};
    vecs[2]  = '{"br",        32'h80,  BR,            1, 1, 0, 32'h103,      0, 32'h100};
    vecs[3]  = '{"bl",        32'h40,  32'h3400_0004, 1, 0, 0, 32'h0,        0, 32'h54};
    vecs[4]  = '{"bcy_t",     32'h20,  32'h3BFF_FFFE, 1, 0, 0, 32'h0,        1, 32'h1C};
    vecs[5]  = '{"bncy_n",    32'h20,  32'h3FFF_FFFE, 1, 0, 0, 32'h0,        1, 32'h24};
    vecs[6]  = '{"bncy_t",    32'h20,  32'h3FFF_FFFE, 1, 0, 0, 32'h0,        0, 32'h1C};
    vecs[7]  = '{"bcy_n",     32'h20,  32'h3BFF_FFFE, 1, 0, 0, 32'h0,        0, 32'h24};
    vecs[8]  = '{"bltz_t",    32'h100, 32'h2000_FFFF, 1, 0, 1, 32'h8000_0000, 0, 32'h100};
    vecs[9]  = '{"bltz_n",    32'h100, 32'h2000_FFFF, 1, 0, 1, 32'h7FFF_FFFF, 0, 32'h104};
    vecs[10] = '{"bnz_t",     32'h200, 32'h2800_0010, 1, 0, 1, 32'h1,        0, 32'h244};
    vecs[11] = '{"bnz_n",     32'h200, 32'h2800_0010, 1, 0, 1, 32'h0,        0, 32'h204};
    vecs[12] = '{"wrap",      32'hFFFF_FFFC, ADD,     0, 0, 0, 32'h0,        0, 32'h0};
    vecs[13] = '{"b_nobr",    32'h30,  32'h3000_0010, 0, 0, 0, 32'h0,        0, 32'h34};
    vecs[14] = '{"b_fwd",     32'h30,  32'h3000_0010, 1, 0, 0, 32'h0,        0, 32'h74};
    vecs[15] = '{"jr_low",    32'h50,  BR,            1, 1, 0, 32'h203,      0, 32'h200};
    vecs[16] = '{"nonbr_op",  32'h60,  32'h0000_0010, 1, 0, 0, 32'h0,        0, 32'h64};

    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_ir", instr, 32'h0);
    chk("rst_cnt", instr_count, 32'h0);
    chk("rst_en", {31'b0, imem_en}, 32'h0);
    chk("rst_ev", {31'b0, exec_valid}, 32'h0);
    chk("rst_halt", {31'b0, halted}, 32'h0);

    mem[0] = ADD; mem[1] = ADD; mem[2] = ADD;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      chk($sformatf("seq_en%0d", c), {31'b0, imem_en}, {31'b0, c % 3 == 0});
      if (c % 3 == 0) chk($sformatf("seq_addr%0d", c), {22'b0, imem_addr}, c / 3);
      chk($sformatf("seq_ev%0d", c), {31'b0, exec_valid}, {31'b0, c % 3 == 2});
      @(negedge clk); #1;
    end
    chk("seq_cnt", instr_count, 32'd3);
    chk("seq_pc", pc, 32'hC);

    mem[0] = ADD;
    do_reset();
    stall = 1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("stall_ev%0d", i), {31'b0, exec_valid}, 32'h0);
      chk($sformatf("stall_pc%0d", i), pc, 32'h0);
      chk($sformatf("stall_cnt%0d", i), instr_count, 32'h0);
      @(negedge clk);
    end
    stall = 0;
    #1;
    chk("stall_drop_ev", {31'b0, exec_valid}, 32'h1);
    commit("stall_commit", 32'h4, 32'h4);
    chk("stall_cnt_after", instr_count, 32'd1);

    mem[0] = 32'hFFFF_FFFF;
    do_reset();
    ev = 0;
    for (int i = 0; i < 12; i++) begin
      if (exec_valid) ev++;
      @(negedge clk); #1;
    end
    chk("halt_ev", ev, 0);
    chk("halt_flag", {31'b0, halted}, 32'h1);
    chk("halt_pc", pc, 32'h0);
    chk("halt_cnt", instr_count, 32'h0);
    chk("halt_en", {31'b0, imem_en}, 32'h0);
    chk("halt_ir", instr, 32'hFFFF_FFFF);
    rst = 1; #1;
    chk("halt_exit", {31'b0, halted}, 32'h0);

    mem[0] = BR;
    do_reset();
    drive(1, 1, 0, 32'h40, 0);
    commit("abort_pre", 32'h40, 32'h4);
    mem[16] = ADD;
    @(posedge clk); #1;
    rst = 1; #1;
    chk("abort_pc", pc, 32'h0);
    chk("abort_cnt", instr_count, 32'h0);
    chk("abort_ev", {31'b0, exec_valid}, 32'h0);
    @(negedge clk);
    mem[0] = ADD;
    drive(0, 0, 0, 0, 0);
    rst = 0; #1;
    commit("abort_post", 32'h4, 32'h4);
    chk("abort_cnt_post", instr_count, 32'd1);

    foreach (vecs[k]) begin
      mem[0] = BR;
      do_reset();
      drive(1, 1, 0, vecs[k].start, 0);
      commit({vecs[k].nm, "_pre"}, vecs[k].start, 32'h4);
      mem[vecs[k].start[11:2]] = vecs[k].ins;
      drive(vecs[k].ib, vecs[k].ja, vecs[k].ls, vecs[k].rs, vecs[k].cy);
      commit(vecs[k].nm, vecs[k].exp, vecs[k].start + 32'd4);
      chk({vecs[k].nm, "_cnt"}, instr_count, 32'd2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Instruction-fetch and PC-sequencing stage of the single-cycle KGP-RISC datapath; sits directly upstream of the control unit.
- Owns the PC and the instruction register (IR), and drives the synchronous instruction memory.
- Slices opcode/func out of the IR for the control unit, then consumes the control unit's branch controls (isBranch, JumpAddr, LabelSel) plus rs/carry to compute the next PC.
- Emits the per-instruction commit strobe that gates register-file and data-memory writes.

Parameters:
- IMEM_AW, 10, instruction-memory word-address width (depth 2^IMEM_AW words).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- HALT_INSTR, 32'hFFFF_FFFF, IR encoding that stops the machine.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_en  out  1  instruction-memory read enable.
- imem_addr  out  IMEM_AW  word address, equal to PC[IMEM_AW+1:2].
- imem_rdata  in  32  instruction word, valid one cycle after imem_en.
- stall  in  1  holds EXEC and defers commit (data-memory busy).
- isBranch  in  1  from control unit.
- JumpAddr  in  1  from control unit; selects register target.
- LabelSel  in  1  from control unit; selects 16-bit offset.
- rs_data  in  32  register-file rs read value.
- carry_flag  in  1  registered ALU carry.
- instr  out  32  IR contents.
- opcode  out  6  instr[31:26], to control unit.
- func  out  5  instr[4:0], to control unit.
- pc  out  32  current PC.
- link_addr  out  32  pc+4, written to ra by bl.
- exec_valid  out  1  commit strobe.
- halted  out  1  machine stopped.
- instr_count  out  32  retired-instruction counter.

Behaviour:
- Reset (async, any state): pc=RESET_PC, IR=0, state=FETCH, instr_count=0, halted=0, imem_en=0, exec_valid=0. rst asserted mid-instruction aborts that instruction; there is no commit.
- FSM states:
  - FETCH: imem_en=1, imem_addr from pc → LOAD.
  - LOAD: IR<=imem_rdata → EXEC.
  - EXEC, normal: if IR==HALT_INSTR → HALT, with exec_valid=0 and pc unchanged. Else if stall → remain in EXEC, exec_valid=0. Else commit: exec_valid=1, pc<=next_pc, instr_count+=1, → FETCH.
  - HALT: halted=1, imem_en=0, exec_valid=0. Only rst exits.
- Latency: 3 cycles per instruction with no stall; each stall cycle adds one.
- exec_valid = (state==EXEC) && !stall && IR!=HALT_INSTR. It is combinational and drops in the same cycle stall rises.
- Target computation:
  - seq = pc+4.
  - off16 = sext(IR[15:0])<<2.
  - off26 = sext(IR[25:0])<<2.
  - JumpAddr=1 → target = {rs_data[31:2],2'b00}; the low bits are forced to 0.
  - LabelSel=1 → target = seq+off16.
  - Otherwise → target = seq+off26.
- Branch taken, by opcode, evaluated only when isBranch=1:
  - 001000 bltz: taken if rs_data[31].
  - 001001 bz: taken if rs_data==0.
  - 001010 bnz: taken if rs_data!=0.
  - 001011 br: always taken.
  - 001100 b: always taken.
  - 001101 bl: always taken.
  - 001110 bcy: taken if carry_flag.
  - 001111 bncy: taken if !carry_flag.
  - isBranch=0 → not taken.
- next_pc = taken ? target : seq.
- All 32-bit arithmetic wraps modulo 2^32. pc=32'hFFFF_FFFC with no branch gives next pc=0.
- imem_addr drops the upper PC bits, so addresses alias within the memory depth.
- instr_count wraps at 2^32−1 → 0.
- link_addr is valid whenever state==EXEC; the register-file write of ra is gated by exec_valid.

Decomposition:
- Shared package kgp_pkg holds:
  - opcode constants OP_BLTZ..OP_BNCY (6'b001000..6'b001111);
  - HALT_INSTR default;
  - FSM state typedef fetch_state_t {FETCH, LOAD, EXEC, HALT}.
- One sub-module, branch_resolve: purely combinational. Inputs are opcode, IR offsets, pc, rs_data, carry_flag and the three control bits; outputs are taken and next_pc. It is reused by the pipelined variant.

Test Plan:
- Reset release with RESET_PC=0 and memory holding add instructions at 0,4,8 → imem_addr 0,1,2 on the FETCH cycles; exec_valid pulses every 3rd cycle; instr_count=3 after 9 cycles.
- bz at pc=0x10, offset 16'h0004, rs_data=0 → next pc=0x24. Same instruction with rs_data=5 → next pc=0x14.
- br with rs_data=32'h0000_0103 → pc=0x100. bl at pc=0x40 → link_addr=0x44, exec_valid=1.
- bcy/bncy at pc=0x20, offset 26'h3FFFFFE (−2 words), carry_flag=1 → bcy goes to 0x1C, bncy goes to 0x24.
- stall held high for 4 cycles during EXEC → exec_valid=0 throughout, pc and instr_count frozen; commit occurs on the cycle after stall falls.
- Fetch of 32'hFFFF_FFFF → halted=1, no commit, pc frozen indefinitely. rst asserted mid-LOAD → pc=RESET_PC immediately and the aborted instruction is not counted.
